// File: rtl/mio_bus_responder_pkg.sv
// Shared address map, FSM state and target-decode types for mio_bus_responder.
package mio_bus_responder_pkg;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hF000_0004;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0008;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_LED,
    TGT_SW,
    TGT_CNT,
    TGT_ERR
  } tgt_e;

  // Misaligned addresses are errors regardless of where they point.
  function automatic tgt_e decode(input logic [31:0] addr,
                                  input logic [31:0] ram_bytes,
                                  input logic        cnt_en);
    if (addr[1:0] != 2'b00)                 return TGT_ERR;
    if ((addr - RAM_BASE) < ram_bytes)      return TGT_RAM;
    if (addr == LED_ADDR)                   return TGT_LED;
    if (addr == SW_ADDR)                    return TGT_SW;
    if (cnt_en && (addr == CNT_ADDR))       return TGT_CNT;
    return TGT_ERR;
  endfunction

endpackage

// File: rtl/mio_data_ram.sv
// Single-port word-wide data RAM: synchronous write, combinational read, no reset.
module mio_data_ram #(
  parameter int RAM_WORDS = 1024,
  localparam int AW = $clog2(RAM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mio_bus_responder.sv
// CPU memory-stage responder: RAM, LED, switches and an optional free-running
// counter at 0xF000_0008 enabled by defining MIO_COUNTER_EN.
module mio_bus_responder
  import mio_bus_responder_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int RAM_WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        mem_ifWriteMem,
  input  logic [31:0] Address_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_error
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [3:0]  RAM_W     = 4'(RAM_WAIT);

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  tgt_e          tgt_now, tgt_q;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q, snap_q, snap_d;
  logic [31:0]   ram_rdata, cnt_q;
  logic [31:0]   rdata_q;
  logic          ready_q, err_q;
  logic [15:0]   led_q;
  logic          latch, commit, ram_we;

`ifdef MIO_COUNTER_EN
  localparam logic CNT_EN = 1'b1;

  // A committing write takes priority over the increment.
  always_ff @(posedge clk) begin
    if (rst)                                    cnt_q <= '0;
    else if (commit && we_q && tgt_q == TGT_CNT) cnt_q <= wdata_q;
    else                                        cnt_q <= cnt_q + 32'd1;
  end
`else
  localparam logic CNT_EN = 1'b0;
  assign cnt_q = '0;
`endif

  assign tgt_now = decode(Address_out, RAM_BYTES, CNT_EN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          if (tgt_now == TGT_RAM && RAM_W != 4'd0) begin
            state_d = ST_WAIT;
            wcnt_d  = RAM_W - 4'd1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    latch  = (state_q == ST_IDLE) && CPU_MIO;
    commit = (state_q == ST_RESP);
    ram_we = commit && we_q && (tgt_q == TGT_RAM) && !rst;
  end

  // Non-RAM read data is captured at the latch edge so later input changes
  // (switches, counter ticks) cannot disturb the transaction.
  always_comb begin
    snap_d = '0;
    case (tgt_now)
      TGT_LED: snap_d = {16'h0000, led_q};
      TGT_SW:  snap_d = {16'h0000, sw_in};
      TGT_CNT: snap_d = cnt_q;
      default: snap_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      tgt_q   <= tgt_now;
      we_q    <= mem_ifWriteMem;
      idx_q   <= Address_out[AW+1:2];
      wdata_q <= Data_out;
      snap_q  <= snap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= commit;
      if (commit && !we_q) rdata_q <= (tgt_q == TGT_RAM) ? ram_rdata : snap_q;
      else                 rdata_q <= '0;
      if (commit && we_q && tgt_q == TGT_LED) led_q <= wdata_q[15:0];
      if (commit && tgt_q == TGT_ERR)         err_q <= 1'b1;
    end
  end

  mio_data_ram #(
    .RAM_WORDS(RAM_WORDS)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  assign Data_in   = rdata_q;
  assign MIO_ready = ready_q;
  assign led_out   = led_q;
  assign bus_error = err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized self-checking bench for mio_bus_responder with a transaction-level model.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        mem_ifWriteMem = 1'b0;
  logic [31:0] Address_out = '0;
  logic [31:0] Data_out = '0;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        bus_error;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  localparam int W_RAM = 1;
`ifdef MIO_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  mio_bus_responder #(.RAM_WORDS(1024), .RAM_WAIT(W_RAM)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_ifWriteMem(mem_ifWriteMem),
    .Address_out(Address_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .sw_in(sw_in), .led_out(led_out), .bus_error(bus_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [15:0] m_led = '0;
  logic        m_err = 1'b0;
  logic [31:0] cnt_base = '0;
  int          cnt_base_edge = 0;

  function automatic logic [31:0] cnt_at(input int k);
    return cnt_base + 32'(k - cnt_base_edge);
  endfunction

  // Expected outcome of a transaction latched at edge n, then model update.
  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int n, output int e_lat, output logic [31:0] e_data,
                           output logic e_err);
    int kind;
    int idx;
    idx = int'(a[11:2]);
    if (a[1:0] != 2'b00)                 kind = 4;
    else if (a < 32'd4096)               kind = 0;
    else if (a == 32'hF000_0000)         kind = 1;
    else if (a == 32'hF000_0004)         kind = 2;
    else if (a == 32'hF000_0008 && CNT_EN) kind = 3;
    else                                 kind = 4;
    e_lat  = (kind == 0) ? 1 + W_RAM : 1;
    e_err  = m_err | (kind == 4);
    e_data = '0;
    if (!w) begin
      case (kind)
        0: e_data = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
        1: e_data = {16'h0, m_led};
        2: e_data = {16'h0, sw_in};
        3: e_data = cnt_at(n - 1);
        default: e_data = '0;
      endcase
    end else begin
      case (kind)
        0: m_ram[idx] = d;
        1: m_led = d[15:0];
        3: begin cnt_base = d; cnt_base_edge = n + 1 + 0; end
        default: ;
      endcase
    end
    m_err = e_err;
  endtask

  // Drives one request, scrambles the inputs after the latch edge, and waits
  // (bounded) for the completion pulse.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int n, output int lat, output logic [31:0] rd,
                       output logic er, output logic drop_ok);
    @(negedge clk);
    CPU_MIO = 1'b1; mem_ifWriteMem = w; Address_out = a; Data_out = d;
    @(posedge clk);
    @(negedge clk);
    n = edge_cnt;
    CPU_MIO = 1'b0;
    mem_ifWriteMem = 1'($urandom);
    Address_out = $urandom;
    Data_out = $urandom;
    lat = 0;
    while (!MIO_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = Data_in;
    er = bus_error;
    @(negedge clk);
    drop_ok = (MIO_ready === 1'b0) && (Data_in === 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; CPU_MIO = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_base = '0; cnt_base_edge = edge_cnt; m_led = '0; m_err = 1'b0;
    checks++; if (MIO_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", MIO_ready); end
    checks++; if (Data_in !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", Data_in); end
    checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led got %h want 0", led_out); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus_error); end
  endtask

  task automatic test_ram();
    int n, lat, e_lat; logic [31:0] rd, e_d; logic er, e_er, dr;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, n, lat, rd, er, dr);
    model_txn(1'b1, 32'h10, 32'hDEAD_BEEF, n, e_lat, e_d, e_er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ram_wr_lat got %0d want 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_wr_data got %h want 0", rd); end
    issue(1'b0, 32'h10, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'h10, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ram_rd_lat got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_data got %h want deadbeef", rd); end
    checks++; if (!dr) begin errors++; $display("FAIL ram_rd_pulse got wide pulse want one cycle"); end
  endtask

  task automatic test_led_sw();
    int n, lat, e_lat; logic [31:0] rd, e_d; logic er, e_er, dr;
    issue(1'b1, 32'hF000_0000, 32'h0000_A5A5, n, lat, rd, er, dr);
    model_txn(1'b1, 32'hF000_0000, 32'h0000_A5A5, n, e_lat, e_d, e_er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL led_lat got %0d want 1", lat); end
    checks++; if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_val got %h want a5a5", led_out); end
    sw_in = 16'h1234;
    issue(1'b0, 32'hF000_0004, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'hF000_0004, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL sw_rd got %h want 00001234", rd); end
    issue(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, n, lat, rd, er, dr);
    model_txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, n, e_lat, e_d, e_er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_wr_err got %b want 0", er); end
    issue(1'b0, 32'hF000_0000, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'hF000_0000, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (rd !== 32'h0000_A5A5) begin errors++; $display("FAIL led_rd got %h want 0000a5a5", rd); end
  endtask

  task automatic test_counter();
    int n, lat, e_lat; logic [31:0] rd, e_d; logic er, e_er, dr;
    issue(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, n, lat, rd, er, dr);
    model_txn(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, n, e_lat, e_d, e_er);
    checks++; if (er !== e_er) begin errors++; $display("FAIL cnt_wr_err got %b want %b", er, e_er); end
    issue(1'b0, 32'hF000_0008, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'hF000_0008, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (rd !== e_d) begin errors++; $display("FAIL cnt_rd got %h want %h", rd, e_d); end
    checks++; if (er !== e_er) begin errors++; $display("FAIL cnt_rd_err got %b want %b", er, e_er); end
    repeat (5) @(negedge clk);
    issue(1'b0, 32'hF000_0008, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'hF000_0008, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (rd !== e_d) begin errors++; $display("FAIL cnt_rd2 got %h want %h", rd, e_d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    d1 = {16'h0, 16'($urandom)};
    d2 = {16'h0, 16'($urandom)};
    @(negedge clk);
    CPU_MIO = 1'b1; mem_ifWriteMem = 1'b1; Address_out = 32'hF000_0000; Data_out = d1;
    @(posedge clk); @(negedge clk);
    checks++; if (MIO_ready !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", MIO_ready); end
    @(negedge clk);
    checks++; if (MIO_ready !== 1'b1 || led_out !== d1[15:0]) begin errors++; $display("FAIL b2b_first got rdy %b led %h want 1 %h", MIO_ready, led_out, d1[15:0]); end
    Data_out = d2;
    @(negedge clk);
    checks++; if (MIO_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", MIO_ready); end
    CPU_MIO = 1'b0;
    @(negedge clk);
    checks++; if (MIO_ready !== 1'b1 || led_out !== d2[15:0]) begin errors++; $display("FAIL b2b_second got rdy %b led %h want 1 %h", MIO_ready, led_out, d2[15:0]); end
    m_led = d2[15:0];
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, lat, e_lat, r; logic [31:0] a, d, rd, e_d; logic w, er, e_er, dr;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      issue(1'b1, 32'(i * 4), d, n, lat, rd, er, dr);
      model_txn(1'b1, 32'(i * 4), d, n, e_lat, e_d, e_er);
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL pre_lat got %0d want %0d", lat, e_lat); end
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      w = 1'($urandom);
      d = $urandom;
      sw_in = 16'($urandom);
      case (r)
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 15) * 4);
        5: a = 32'hF000_0000;
        6: a = 32'hF000_0004;
        7: a = 32'hF000_0008;
        8: a = 32'h8000_0000 + {14'h0, 16'($urandom), 2'b00};
        default: a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
      endcase
      issue(w, a, d, n, lat, rd, er, dr);
      model_txn(w, a, d, n, e_lat, e_d, e_er);
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd_lat a=%h got %0d want %0d", a, lat, e_lat); end
      checks++; if (rd !== e_d) begin errors++; $display("FAIL rnd_data a=%h w=%b got %h want %h", a, w, rd, e_d); end
      checks++; if (er !== e_er) begin errors++; $display("FAIL rnd_err a=%h got %b want %b", a, er, e_er); end
      checks++; if (led_out !== m_led) begin errors++; $display("FAIL rnd_led got %h want %h", led_out, m_led); end
      checks++; if (!dr) begin errors++; $display("FAIL rnd_pulse a=%h got wide pulse want one cycle", a); end
    end
  endtask

  task automatic test_bus_error();
    int n, lat, e_lat; logic [31:0] rd, e_d; logic er, e_er, dr;
    issue(1'b0, 32'h0000_0012, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'h0000_0012, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL misalign got lat %0d data %h err %b want 1 0 1", lat, rd, er); end
    issue(1'b0, 32'h8000_0000, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'h8000_0000, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL unmapped got lat %0d data %h err %b want 1 0 1", lat, rd, er); end
    issue(1'b1, 32'h0000_0013, 32'h1111_2222, n, lat, rd, er, dr);
    model_txn(1'b1, 32'h0000_0013, 32'h1111_2222, n, e_lat, e_d, e_er);
    issue(1'b0, 32'h0000_0010, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'h0000_0010, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (rd !== e_d) begin errors++; $display("FAIL misalign_nowrite got %h want %h", rd, e_d); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", er); end
  endtask

  task automatic test_reset_mid_wait();
    int n, lat, e_lat; logic [31:0] rd, e_d; logic er, e_er, dr;
    issue(1'b1, 32'h40, 32'h1234_5678, n, lat, rd, er, dr);
    model_txn(1'b1, 32'h40, 32'h1234_5678, n, e_lat, e_d, e_er);
    issue(1'b1, 32'hF000_0000, 32'h0000_FFFF, n, lat, rd, er, dr);
    model_txn(1'b1, 32'hF000_0000, 32'h0000_FFFF, n, e_lat, e_d, e_er);
    @(negedge clk);
    CPU_MIO = 1'b1; mem_ifWriteMem = 1'b1; Address_out = 32'h40; Data_out = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    CPU_MIO = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cnt_base = '0; cnt_base_edge = edge_cnt; m_led = '0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (MIO_ready !== 1'b0 || Data_in !== 32'h0 || led_out !== 16'h0 || bus_error !== 1'b0) begin
        errors++;
        $display("FAIL midrst_outs got rdy %b data %h led %h err %b want all 0", MIO_ready, Data_in, led_out, bus_error);
      end
      @(negedge clk);
    end
    issue(1'b0, 32'h40, 32'h0, n, lat, rd, er, dr);
    model_txn(1'b0, 32'h40, 32'h0, n, e_lat, e_d, e_er);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL midrst_ram got %h want 12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_sw();
    test_counter();
    test_back_to_back();
    test_random();
    test_bus_error();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024: data RAM depth in 32-bit words, power of two.
REQ-002 Parameter RAM_WAIT, default 1: RAM wait states, range 0-15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 CPU_MIO  input  1  request valid from CPU memory stage.
REQ-006 mem_ifWriteMem  input  1  1 = write, 0 = read; qualified by CPU_MIO.
REQ-007 Address_out  input  32  byte address from CPU.
REQ-008 Data_out  input  32  CPU write data.
REQ-009 Data_in  output  32  read data to CPU.
REQ-010 MIO_ready  output  1  one-cycle completion pulse.
REQ-011 sw_in  input  16  board switches.
REQ-012 led_out  output  16  LED register.
REQ-013 bus_error  output  1  sticky error flag.

Function
REQ-014 The block SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-015 In IDLE with CPU_MIO=1 at edge N, the block SHALL latch address, write data and write flag; later input changes SHALL NOT affect the transaction.
REQ-016 Wait count W SHALL be RAM_WAIT for RAM, 0 for all other addresses; WAIT SHALL be skipped when W=0.
REQ-017 MIO_ready SHALL be 1 for exactly the cycle N+1+W, then FSM SHALL return to IDLE.
REQ-018 CPU_MIO SHALL be ignored outside IDLE; a request still held in the cycle after RESP SHALL start a new transaction.
REQ-019 Data_in SHALL carry read data only while MIO_ready=1, else 0; for writes it SHALL be 0.
REQ-020 Writes SHALL commit on the edge that raises MIO_ready.
REQ-021 Address map: 0x0000_0000 to RAM_WORDS*4-1 RAM (R/W); 0xF000_0000 LED (R/W, bits 15:0, read zero-extended); 0xF000_0004 switches (RO, zero-extended); 0xF000_0008 counter (when enabled).
REQ-022 RAM index SHALL be Address_out[log2(RAM_WORDS)+1:2].
REQ-023 Writes to read-only locations SHALL be discarded without error.
REQ-024 Unmapped or misaligned (bits 1:0 != 0) access SHALL perform no write, return 0, set bus_error, still pulse MIO_ready.
REQ-025 bus_error SHALL stay 1 until reset.

Reset
REQ-026 On rst=1 at an edge: FSM IDLE, MIO_ready 0, Data_in 0, led_out 0, bus_error 0, counter 0; RAM contents not reset.
REQ-027 Reset mid-transaction SHALL abandon it with no MIO_ready pulse and no write unless already committed.

Configuration
REQ-028 Macro MIO_COUNTER_EN defined: 32-bit counter at 0xF000_0008, +1 every cycle, wraps 0xFFFF_FFFF -> 0, write loads Data_out (write wins over increment), read returns value at latch edge.
REQ-029 MIO_COUNTER_EN undefined: no counter logic; 0xF000_0008 is unmapped (REQ-024).

Structure
REQ-030 Shared package SHALL hold address-map constants (RAM base, LED, SW, CNT addresses) and the FSM state enum.
REQ-031 RAM SHALL be sub-module mio_data_ram: synchronous-write, word-wide, single port.

Verification
REQ-032 RAM_WAIT=1: write 0xDEAD_BEEF to 0x10 at edge N -> MIO_ready at cycle N+2; read 0x10 -> Data_in=0xDEAD_BEEF with MIO_ready.
REQ-033 Write 0x0000_A5A5 to 0xF000_0000 -> led_out=0xA5A5 after ready (W=0, ready at N+1); sw_in=0x1234, read 0xF000_0004 -> 0x0000_1234.
REQ-034 Read 0x0000_0012 (misaligned) and 0x8000_0000 (unmapped) -> Data_in=0, MIO_ready pulses, bus_error=1 and held.
REQ-035 MIO_COUNTER_EN: write 0xFFFF_FFFE to counter, read two cycles later -> value wrapped through 0; without macro -> bus_error.
REQ-036 Assert rst during WAIT of RAM write -> no MIO_ready, RAM word unchanged, all outputs at reset values.
